// File: rtl/mmio_host_sequencer.sv
// Hardware MMIO initiator: programs the DMA/RO or RSA registers, issues go,
// then polls the done register until it is set or the timeout expires.
module mmio_host_sequencer #(
    parameter int ADDR_WIDTH      = 64,
    parameter int SIZE_WIDTH      = 32,
    parameter int MMIO_ADDR_WIDTH = 16,
    parameter int MMIO_DATA_WIDTH = 64,
    parameter int POLL_INTERVAL   = 8,
    parameter int TIMEOUT_CYCLES  = 1048576
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       cfg_mode,
    input  logic [ADDR_WIDTH-1:0]      cfg_rd_addr,
    input  logic [ADDR_WIDTH-1:0]      cfg_wr_addr,
    input  logic [SIZE_WIDTH-1:0]      cfg_num_samples,
    input  logic [SIZE_WIDTH-1:0]      cfg_collect_cycles,
    output logic                       mmio_wr_en,
    output logic [MMIO_ADDR_WIDTH-1:0] mmio_wr_addr,
    output logic [MMIO_DATA_WIDTH-1:0] mmio_wr_data,
    output logic                       mmio_rd_en,
    output logic [MMIO_ADDR_WIDTH-1:0] mmio_rd_addr,
    input  logic [MMIO_DATA_WIDTH-1:0] mmio_rd_data,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic [15:0]                poll_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [GW-1:0] G_LOAD = GW'(POLL_INTERVAL - 1);

    localparam logic [MMIO_ADDR_WIDTH-1:0] A_RDADDR = MMIO_ADDR_WIDTH'(16'h0052);
    localparam logic [MMIO_ADDR_WIDTH-1:0] A_WRADDR = MMIO_ADDR_WIDTH'(16'h0054);
    localparam logic [MMIO_ADDR_WIDTH-1:0] A_NUM    = MMIO_ADDR_WIDTH'(16'h0056);
    localparam logic [MMIO_ADDR_WIDTH-1:0] A_CYC    = MMIO_ADDR_WIDTH'(16'h0058);
    localparam logic [MMIO_ADDR_WIDTH-1:0] A_RO_GO  = MMIO_ADDR_WIDTH'(16'h0050);
    localparam logic [MMIO_ADDR_WIDTH-1:0] A_RSA_GO = MMIO_ADDR_WIDTH'(16'h0072);
    localparam logic [MMIO_ADDR_WIDTH-1:0] A_RO_DN  = MMIO_ADDR_WIDTH'(16'h0060);
    localparam logic [MMIO_ADDR_WIDTH-1:0] A_RSA_DN = MMIO_ADDR_WIDTH'(16'h0074);

    typedef enum logic [3:0] {
        IDLE, W_RDADDR, W_WRADDR, W_NUM, W_CYC,
        W_GO, P_REQ, P_WAIT, P_GAP, FIN
    } state_t;

    state_t state, state_n;

    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [SIZE_WIDTH-1:0] num_q;
    logic [SIZE_WIDTH-1:0] cyc_q;
    logic [TW-1:0]         tcnt;
    logic [GW-1:0]         gcnt;

    logic accept, expired, abort, go_mode;
    logic wr_en_n, rd_en_n;
    logic [MMIO_ADDR_WIDTH-1:0] wr_addr_n, rd_addr_n;
    logic [MMIO_DATA_WIDTH-1:0] wr_data_n;
    logic unused_rd_bits;

    assign accept  = (state == IDLE) && start;
    assign expired = (tcnt >= T_MAX);
    // W_GO is entered straight from IDLE in RSA mode, before mode_q is loaded
    assign go_mode = (state == IDLE) ? cfg_mode : mode_q;
    assign unused_rd_bits = ^mmio_rd_data[MMIO_DATA_WIDTH-1:1];

    always_comb begin
        state_n = state;
        abort   = 1'b0;
        unique case (state)
            IDLE:     if (start) state_n = cfg_mode ? W_GO : W_RDADDR;
            W_RDADDR: state_n = W_WRADDR;
            W_WRADDR: state_n = W_NUM;
            W_NUM:    state_n = W_CYC;
            W_CYC:    state_n = W_GO;
            W_GO:     state_n = P_REQ;
            P_REQ: begin
                if (expired) begin
                    state_n = FIN;
                    abort   = 1'b1;
                end else begin
                    state_n = P_WAIT;
                end
            end
            P_WAIT: begin
                if (mmio_rd_data[0]) begin
                    state_n = FIN;
                end else if (expired) begin
                    state_n = FIN;
                    abort   = 1'b1;
                end else begin
                    state_n = P_GAP;
                end
            end
            P_GAP: begin
                if (expired) begin
                    state_n = FIN;
                    abort   = 1'b1;
                end else if (gcnt == '0) begin
                    state_n = P_REQ;
                end
            end
            FIN:      state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Outputs are registered from the state being entered
    always_comb begin
        wr_en_n   = 1'b0;
        wr_addr_n = '0;
        wr_data_n = '0;
        rd_en_n   = 1'b0;
        rd_addr_n = '0;
        unique case (state_n)
            W_RDADDR: begin
                wr_en_n   = 1'b1;
                wr_addr_n = A_RDADDR;
                wr_data_n = MMIO_DATA_WIDTH'(cfg_rd_addr);
            end
            W_WRADDR: begin
                wr_en_n   = 1'b1;
                wr_addr_n = A_WRADDR;
                wr_data_n = MMIO_DATA_WIDTH'(wr_addr_q);
            end
            W_NUM: begin
                wr_en_n   = 1'b1;
                wr_addr_n = A_NUM;
                wr_data_n = MMIO_DATA_WIDTH'(num_q);
            end
            W_CYC: begin
                wr_en_n   = 1'b1;
                wr_addr_n = A_CYC;
                wr_data_n = MMIO_DATA_WIDTH'(cyc_q);
            end
            W_GO: begin
                wr_en_n   = 1'b1;
                wr_addr_n = go_mode ? A_RSA_GO : A_RO_GO;
                wr_data_n = MMIO_DATA_WIDTH'(1);
            end
            P_REQ: begin
                rd_en_n   = 1'b1;
                rd_addr_n = mode_q ? A_RSA_DN : A_RO_DN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mmio_wr_en   <= 1'b0;
            mmio_wr_addr <= '0;
            mmio_wr_data <= '0;
            mmio_rd_en   <= 1'b0;
            mmio_rd_addr <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            poll_count   <= '0;
            mode_q       <= 1'b0;
            wr_addr_q    <= '0;
            num_q        <= '0;
            cyc_q        <= '0;
            tcnt         <= '0;
            gcnt         <= '0;
        end else begin
            state        <= state_n;
            mmio_wr_en   <= wr_en_n;
            mmio_wr_addr <= wr_addr_n;
            mmio_wr_data <= wr_data_n;
            mmio_rd_en   <= rd_en_n;
            mmio_rd_addr <= rd_addr_n;
            busy         <= (state_n != IDLE);
            done         <= (state_n == FIN);
            if (accept) begin
                mode_q     <= cfg_mode;
                wr_addr_q  <= cfg_wr_addr;
                num_q      <= cfg_num_samples;
                cyc_q      <= cfg_collect_cycles;
                timeout    <= 1'b0;
                poll_count <= '0;
            end else begin
                if (abort)
                    timeout <= 1'b1;
                if (state_n == P_REQ && poll_count != 16'hFFFF)
                    poll_count <= poll_count + 16'd1;
            end
            if (state_n == W_GO)
                tcnt <= '0;
            else if (!expired)
                tcnt <= tcnt + TW'(1);
            if (state == P_WAIT)
                gcnt <= G_LOAD;
            else if (state == P_GAP && gcnt != '0)
                gcnt <= gcnt - GW'(1);
        end
    end

endmodule
